// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS receive constants, control tokens and lock states
package tmds_pkg;

  localparam int SYM_W = 10;
  localparam int OFF_W = 4;
  localparam logic [OFF_W-1:0] OFF_MAX = 4'd9;

  localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational 10b symbol classifier and 10b->8b data decoder
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output logic             is_ctrl_o,
  output logic [1:0]       ctrl_o,
  output logic [7:0]       byte_o
);

  logic [7:0] d;

  always_comb begin
    d         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    byte_o    = '0;
    byte_o[0] = d[0];
    // bit 8 selects XOR vs XNOR transition coding
    for (int i = 1; i < 8; i++) begin
      byte_o[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    case (sym_i)
      TOK_00:  ctrl_o = 2'b00;
      TOK_01:  ctrl_o = 2'b01;
      TOK_10:  ctrl_o = 2'b10;
      TOK_11:  ctrl_o = 2'b11;
      default: is_ctrl_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS lane: bit alignment on control-token runs, 10b->8b decode
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN  = 8,
  parameter int TIMEOUT   = 2048,
  parameter int TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] din,
  output logic [7:0]       data,
  output logic             de,
  output logic             c0,
  output logic             c1,
  output logic             locked,
  output logic [OFF_W-1:0] offset,
  output logic             lock_lost
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);

  lock_state_e          state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [SYM_W-1:0]     prev_q, sym_q;
  logic [2*SYM_W-1:0]   shifted;
  logic [7:0]           data_q, data_d;
  logic                 de_q, de_d;
  logic [1:0]           c_q, c_d;
  logic                 lost_q, lost_d;

  logic                 is_ctrl;
  logic [1:0]           ctrl;
  logic [7:0]           dec_byte;

  // offset change applies to the very next symbol; no flush
  always_comb begin
    shifted = {din, prev_q} >> offset_q;
  end

  tmds_symbol_decode u_dec (
    .sym_i     (sym_q),
    .is_ctrl_o (is_ctrl),
    .ctrl_o    (ctrl),
    .byte_o    (dec_byte)
  );

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    offset_d = offset_q;
    lost_d   = 1'b0;
    tmo_inc  = tmo_q + 1'b1;

    case (state_q)
      SEARCH: begin
        if (is_ctrl) begin
          tmo_d = '0;
          if (run_q >= RUN_W'(CTRL_RUN - 1)) begin
            run_d   = RUN_W'(CTRL_RUN);
            state_d = LOCKED;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else begin
          run_d = '0;
          if (tmo_inc == TIMEOUT_W'(TIMEOUT)) begin
            tmo_d    = '0;
            offset_d = (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          tmo_d = '0;
        end else if (tmo_inc == TIMEOUT_W'(TIMEOUT)) begin
          state_d = SEARCH;
          run_d   = '0;
          tmo_d   = '0;
          lost_d  = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // gating follows the next state so de never shows while locked reads 0
  always_comb begin
    data_d = '0;
    de_d   = 1'b0;
    c_d    = c_q;
    if (state_d == LOCKED) begin
      if (is_ctrl) begin
        c_d = ctrl;
      end else begin
        de_d   = 1'b1;
        data_d = dec_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      run_q    <= '0;
      tmo_q    <= '0;
      offset_q <= '0;
      prev_q   <= '0;
      sym_q    <= '0;
      data_q   <= '0;
      de_q     <= 1'b0;
      c_q      <= 2'b00;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      offset_q <= offset_d;
      prev_q   <= din;
      sym_q    <= shifted[SYM_W-1:0];
      data_q   <= data_d;
      de_q     <= de_d;
      c_q      <= c_d;
      lost_q   <= lost_d;
    end
  end

  assign data      = data_q;
  assign de        = de_q;
  assign c0        = c_q[0];
  assign c1        = c_q[1];
  assign locked    = (state_q == LOCKED);
  assign offset    = offset_q;
  assign lock_lost = lost_q;

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
Receive-side counterpart of the DVI transmit path. It takes raw 10-bit words from one TMDS lane deserializer, one word per pixel clock, and bit-aligns them using the control-token runs in blanking. It then decodes 10b→8b pixel data and recovers the two control bits (hsync/vsync on lane 0) and data-enable. One instance is used per lane (blue, green, red) in the receiver top.

Parameters:
CTRL_RUN, 8, consecutive aligned control tokens required to declare lock
TIMEOUT, 2048, words with no aligned control token before an offset is abandoned (SEARCH) or lock is dropped (LOCKED)
TIMEOUT_W, 12, width of the timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT

Ports:
clk  input  1  pixel clock; all logic on rising edge
rst  input  1  reset; asynchronous, active-low
din  input  10  raw deserialized word; din[0] is the earliest received bit
data  output  8  decoded pixel byte; valid when de=1
de  output  1  data enable; 1 when the symbol is a data symbol and the block is locked
c0  output  1  control bit 0 (hsync on lane 0); holds the last token value during data periods
c1  output  1  control bit 1 (vsync on lane 0); holds the last token value during data periods
locked  output  1  alignment acquired
offset  output  4  current bit-alignment offset, 0..9
lock_lost  output  1  one-clock pulse on the LOCKED→SEARCH transition

Behaviour:
- Reset (rst=0, asynchronous):
  - data=0, de=0, c0=0, c1=0, locked=0, offset=0, lock_lost=0.
  - State=SEARCH; run and timeout counters=0; pipeline registers=0.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
- Alignment window:
  - prev <= din each clock.
  - window = {din, prev} (20 bits); aligned symbol = window[offset+9 : offset].
- Pipeline:
  - Stage 1: prev register.
  - Stage 2: sym_r <= aligned symbol.
  - Stage 3: decoded outputs registered from sym_r.
  - At offset 0, a word on din in cycle n appears on the outputs in cycle n+3. Pipeline depth is fixed at 3 for every offset.
- Token detect (on sym_r):
  - 0x354 → c1c0=00
  - 0x0AB → c1c0=01
  - 0x154 → c1c0=10
  - 0x2AB → c1c0=11
  - Any other value is a data symbol.
- Data decode:
  - d = sym_r[9] ? ~sym_r[7:0] : sym_r[7:0].
  - out[0] = d[0].
  - For i=1..7: out[i] = sym_r[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states: SEARCH, LOCKED.
  - SEARCH:
    - Token: run++ (saturating at CTRL_RUN) and tmo=0.
    - Data symbol: run=0 and tmo++.
    - When a token makes run reach CTRL_RUN → LOCKED, locked=1 on the next clock.
    - When tmo reaches TIMEOUT → offset advances (9 wraps to 0), run=0, tmo=0, state stays SEARCH.
    - Token and timeout in the same cycle: the token wins; tmo clears and no offset advance.
  - LOCKED:
    - Token: tmo=0.
    - Data symbol: tmo++.
    - When tmo reaches TIMEOUT → SEARCH with offset unchanged, run=0, tmo=0, locked=0, lock_lost pulses for 1 clock.
- Output gating:
  - While locked=0: de=0 and data=0; c0/c1 hold their previous value.
  - While locked=1:
    - Token: de=0, data=0, c0/c1 updated.
    - Data symbol: de=1, data=out, c0/c1 hold.
- Offset change mid-stream: the next aligned symbol uses the new offset immediately; there are no flush cycles.

Decomposition:
- Package tmds_pkg:
  - Token constants TOK_00=10'h354, TOK_01=10'h0AB, TOK_10=10'h154, TOK_11=10'h2AB.
  - State enum {SEARCH, LOCKED}.
  - SYM_W=10, OFF_W=4.
- One natural combinational sub-module: tmds_symbol_decode.
  - Input: sym[9:0].
  - Outputs: is_ctrl, ctrl[1:0], byte[7:0].
  - The same module is reusable by the other two lanes and by a TMDS-error checker.

Test Plan:
- Offset-0 lock: 16×0x354 on din, then data → locked=1 on the cycle after the 8th token reaches sym_r; offset=0, c1c0=00, de=0 during tokens.
- Misaligned lock: repeated 0x354 stream delayed by 3 bits, no reset between offsets → offset steps 0→1→2→3 after TIMEOUT words at each non-locking offset; locks with offset=3 and c1c0=00.
- Data decode while locked:
  - 0x100 → data=0x00, de=1.
  - 0x1FF → data=0x01.
  - 0x2FF → data=0xFE.
  - Each appears 3 clocks after presentation.
- Control hold: locked; 4×0x2AB, then 0x100 → c0=1, c1=1 during the tokens and held at 1 during the data symbol while de=1.
- Lock loss: locked, then 2048 consecutive data symbols → lock_lost=1 for exactly one clock, locked=0, de=0, offset unchanged. A following run of 8×0x354 relocks.
- Async reset: drive rst=0 between clock edges while locked → locked, de, data, c0, c1, offset all read 0 before the next rising edge.
